// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg: shared definitions for the retire trace buffer.
//   - flag bit indices inside a trace record
//   - record field widths, total record widths (with and without next_pc)
//   - trace record layout and capture state encoding
// Optional feature macro: RETIRE_TRACE_NEXT_PC_EN (adds next_pc and the
// discontinuity flag to every record).
package retire_trace_pkg;

  localparam int FLAG_TRAP = 0;
  localparam int FLAG_HALT = 1;
  localparam int FLAG_DISC = 2;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  localparam int FLAGS_W_BASE = 2;
  localparam int FLAGS_W_NPC  = 3;
  localparam int REC_W_BASE   = PC_W + INST_W + RD_W + DATA_W + FLAGS_W_BASE;
  localparam int REC_W_NPC    = PC_W + INST_W + RD_W + DATA_W + FLAGS_W_NPC + PC_W;

`ifdef RETIRE_TRACE_NEXT_PC_EN
  localparam int FLAGS_W = FLAGS_W_NPC;
  localparam int REC_W   = REC_W_NPC;
`else
  localparam int FLAGS_W = FLAGS_W_BASE;
  localparam int REC_W   = REC_W_BASE;
`endif

  typedef struct packed {
`ifdef RETIRE_TRACE_NEXT_PC_EN
    logic [PC_W-1:0]    next_pc;
`endif
    logic [FLAGS_W-1:0] flags;
    logic [DATA_W-1:0]  rd_wdata;
    logic [RD_W-1:0]    rd_waddr;
    logic [INST_W-1:0]  inst;
    logic [PC_W-1:0]    pc;
  } trace_rec_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  // Writes to x0 carry no architectural data, so they are traced as zero.
  function automatic logic [DATA_W-1:0] mask_wdata(input logic [RD_W-1:0]   rd,
                                                   input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] res;
    if (rd == {RD_W{1'b0}}) begin
      res = {DATA_W{1'b0}};
    end else begin
      res = wdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic WIDTH x DEPTH synchronous FIFO.
// Ports:
//   i_clk, i_rst   clock / asynchronous active-high reset
//   i_push, i_wdata  write request and data (ignored when full unless popping)
//   i_pop          read request (ignored when empty)
//   o_rdata        head entry, indexed view of storage (stable until popped)
//   o_full, o_empty  occupancy status
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == {CW{1'b0}});
  assign pop_s   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s  = i_push && (!o_full || pop_s);
  assign o_rdata = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: captures one record per retired instruction into a
// FIFO and drains it over a valid/ready stream to a trace sink.
// Ports:
//   i_clk, i_rst            clock / asynchronous active-high reset
//   i_retire_*              hart retire interface (valid, pc, inst, rd, flags)
//   o_trace_valid/i_trace_ready  stream handshake for the head record
//   o_trace_*               head record fields (zero when no record is valid)
//   o_halted                a halt has retired; capture is frozen
//   o_overflow              sticky: at least one record was dropped
//   o_retired_count/o_drop_count  saturating accepted/dropped record counters
// Optional feature macro: RETIRE_TRACE_NEXT_PC_EN adds o_trace_next_pc and a
// discontinuity flag (o_trace_flags[2]).
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_retire_valid,
  input  logic [31:0]        i_retire_inst,
  input  logic               i_retire_trap,
  input  logic               i_retire_halt,
  input  logic [31:0]        i_retire_pc,
  input  logic [31:0]        i_retire_next_pc,
  input  logic [4:0]         i_retire_rd_waddr,
  input  logic [31:0]        i_retire_rd_wdata,
  output logic               o_trace_valid,
  input  logic               i_trace_ready,
  output logic [31:0]        o_trace_pc,
  output logic [31:0]        o_trace_inst,
  output logic [4:0]         o_trace_rd_waddr,
  output logic [31:0]        o_trace_rd_wdata,
`ifdef RETIRE_TRACE_NEXT_PC_EN
  output logic [31:0]        o_trace_next_pc,
`endif
  output logic [FLAGS_W-1:0] o_trace_flags,
  output logic               o_halted,
  output logic               o_overflow,
  output logic [CNT_W-1:0]   o_retired_count,
  output logic [CNT_W-1:0]   o_drop_count
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              overflow_q, overflow_d;

  trace_rec_t        wr_rec_s, head_rec_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              push_req_s, pop_s, accept_s, drop_s;

  assign push_req_s = i_retire_valid && (state_q == RUN);
  assign pop_s      = o_trace_valid && i_trace_ready;
  assign accept_s   = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s     = push_req_s && fifo_full_s && !pop_s;

  // Pack the incoming retire into a record.
  always_comb begin
    wr_rec_s                  = '0;
    wr_rec_s.pc               = i_retire_pc;
    wr_rec_s.inst             = i_retire_inst;
    wr_rec_s.rd_waddr         = i_retire_rd_waddr;
    wr_rec_s.rd_wdata         = mask_wdata(i_retire_rd_waddr, i_retire_rd_wdata);
    wr_rec_s.flags[FLAG_TRAP] = i_retire_trap;
    wr_rec_s.flags[FLAG_HALT] = i_retire_halt;
`ifdef RETIRE_TRACE_NEXT_PC_EN
    wr_rec_s.next_pc          = i_retire_next_pc;
    wr_rec_s.flags[FLAG_DISC] = (i_retire_next_pc != (i_retire_pc + 32'd4));
`endif
  end

`ifndef RETIRE_TRACE_NEXT_PC_EN
  logic unused_next_pc_s;
  assign unused_next_pc_s = ^i_retire_next_pc;
`endif

  trace_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept_s),
    .i_wdata (wr_rec_s),
    .i_pop   (pop_s),
    .o_rdata (head_rec_s),
    .o_full  (fifo_full_s),
    .o_empty (fifo_empty_s)
  );

  assign o_trace_valid = !fifo_empty_s;

  // Unpack the head record; fields read as zero while nothing is buffered.
  always_comb begin
    o_trace_pc       = 32'd0;
    o_trace_inst     = 32'd0;
    o_trace_rd_waddr = 5'd0;
    o_trace_rd_wdata = 32'd0;
    o_trace_flags    = {FLAGS_W{1'b0}};
`ifdef RETIRE_TRACE_NEXT_PC_EN
    o_trace_next_pc  = 32'd0;
`endif
    if (o_trace_valid) begin
      o_trace_pc       = head_rec_s.pc;
      o_trace_inst     = head_rec_s.inst;
      o_trace_rd_waddr = head_rec_s.rd_waddr;
      o_trace_rd_wdata = head_rec_s.rd_wdata;
      o_trace_flags    = head_rec_s.flags;
`ifdef RETIRE_TRACE_NEXT_PC_EN
      o_trace_next_pc  = head_rec_s.next_pc;
`endif
    end else begin
      o_trace_pc       = 32'd0;
    end
  end

  // Capture state, counters and overflow next-state. A halt moves to HALTED
  // even when its own record is dropped.
  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    case (state_q)
      RUN: begin
        if (push_req_s && i_retire_halt) begin
          state_d = HALTED;
        end else begin
          state_d = RUN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (accept_s && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_q != {CNT_W{1'b1}}) begin
        drop_d = drop_q + CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      drop_d = drop_q;
    end
  end

  // State, counter and overflow registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= RUN;
      retired_q  <= {CNT_W{1'b0}};
      drop_q     <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retired_q  <= retired_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_halted        = (state_q == HALTED);
  assign o_overflow      = overflow_q;
  assign o_retired_count = retired_q;
  assign o_drop_count    = drop_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed testbench for retire_trace_buffer (DEPTH = 16, CNT_W = 32).
module tb_retire_trace_buffer;

  logic        clk;
  logic        rst;
  logic        rv;
  logic [31:0] inst;
  logic        trap;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [4:0]  rdw;
  logic [31:0] rdd;
  logic        ready;

  logic        t_valid;
  logic [31:0] t_pc;
  logic [31:0] t_inst;
  logic [4:0]  t_rd;
  logic [31:0] t_data;
`ifdef RETIRE_TRACE_NEXT_PC_EN
  logic [31:0] t_npc;
  logic [2:0]  t_flags;
`else
  logic [1:0]  t_flags;
`endif
  logic        halted;
  logic        overflow;
  logic [31:0] ret_cnt;
  logic [31:0] drop_cnt;

  int tests;
  int fails;

  retire_trace_buffer #(.DEPTH(16), .CNT_W(32)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_retire_valid    (rv),
    .i_retire_inst     (inst),
    .i_retire_trap     (trap),
    .i_retire_halt     (halt),
    .i_retire_pc       (pc),
    .i_retire_next_pc  (npc),
    .i_retire_rd_waddr (rdw),
    .i_retire_rd_wdata (rdd),
    .o_trace_valid     (t_valid),
    .i_trace_ready     (ready),
    .o_trace_pc        (t_pc),
    .o_trace_inst      (t_inst),
    .o_trace_rd_waddr  (t_rd),
    .o_trace_rd_wdata  (t_data),
`ifdef RETIRE_TRACE_NEXT_PC_EN
    .o_trace_next_pc   (t_npc),
`endif
    .o_trace_flags     (t_flags),
    .o_halted          (halted),
    .o_overflow        (overflow),
    .o_retired_count   (ret_cnt),
    .o_drop_count      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d,
                        input logic tr, input logic h);
    rv   = 1'b1;
    pc   = p;
    npc  = p + 32'd4;
    inst = 32'h0000_0013 ^ p;
    rdw  = r;
    rdd  = d;
    trap = tr;
    halt = h;
  endtask

  task automatic idle();
    rv   = 1'b0;
    trap = 1'b0;
    halt = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; rv = 1'b0; inst = 32'd0; trap = 1'b0; halt = 1'b0;
    pc = 32'd0; npc = 32'd0; rdw = 5'd0; rdd = 32'd0; ready = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_valid", t_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_ret_cnt", ret_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_pc", t_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Three retires streamed through with ready high, latency one cycle
    ready = 1'b1;
    retire(32'h0, 5'd1, 32'h11, 1'b0, 1'b0);
    tick();
    chk("s_valid0", t_valid, 1'b1);
    chk("s_pc0", t_pc, 32'h0);
    chk("s_inst0", t_inst, 32'h0000_0013);
    retire(32'h4, 5'd1, 32'h22, 1'b0, 1'b0);
    tick();
    chk("s_pc1", t_pc, 32'h4);
    retire(32'h8, 5'd1, 32'h33, 1'b0, 1'b0);
    tick();
    chk("s_pc2", t_pc, 32'h8);
    chk("s_data2", t_data, 32'h33);
    idle();
    tick();
    chk("s_empty", t_valid, 1'b0);
    chk("s_ret_cnt", ret_cnt, 32'd3);

    // Twenty retires into a stalled sink: 16 held, 4 dropped
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      retire(32'(i * 4), 5'd2, 32'(i), 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("f_overflow", overflow, 1'b1);
    chk("f_drop_cnt", drop_cnt, 32'd4);
    chk("f_ret_cnt", ret_cnt, 32'd19);
    chk("f_occ", dut.u_fifo.count_q, 5'd16);
    chk("f_head", t_pc, 32'h0);
    tick();
    chk("f_head_stable", t_pc, 32'h0);
    chk("f_valid_stable", t_valid, 1'b1);

    // Push and pop together while full
    ready = 1'b1;
    retire(32'h100, 5'd3, 32'h5, 1'b0, 1'b0);
    tick();
    idle();
    chk("pp_occ", dut.u_fifo.count_q, 5'd16);
    chk("pp_drop_cnt", drop_cnt, 32'd4);
    chk("pp_ret_cnt", ret_cnt, 32'd20);
    for (int i = 1; i < 16; i++) begin
      chk("drain_pc", t_pc, 64'(i * 4));
      tick();
    end
    chk("drain_pc16", t_pc, 32'h100);
    tick();
    chk("drain_empty", t_valid, 1'b0);

    // rd = 0 masks data, rd = 10 keeps data, trap flag only
    retire(32'h200, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    idle();
    chk("rd0_addr", t_rd, 5'd0);
    chk("rd0_data", t_data, 32'd0);
    tick();
    retire(32'h204, 5'd10, 32'h2A, 1'b0, 1'b0);
    tick();
    idle();
    chk("rd10_addr", t_rd, 5'd10);
    chk("rd10_data", t_data, 32'h2A);
    chk("rd10_flags", t_flags[1:0], 2'b00);
    tick();
    retire(32'h208, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    chk("trap_flags", t_flags[1:0], 2'b01);
    chk("trap_halted", halted, 1'b0);
    tick();
    chk("trap_empty", t_valid, 1'b0);
    chk("trap_ret_cnt", ret_cnt, 32'd23);

    // Halt freezes capture
    ready = 1'b0;
    retire(32'h40, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    retire(32'h44, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    retire(32'h48, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("h_halted", halted, 1'b1);
    chk("h_ret_cnt", ret_cnt, 32'd24);
    chk("h_occ", dut.u_fifo.count_q, 5'd1);
    chk("h_pc", t_pc, 32'h40);
    chk("h_flags", t_flags[1:0], 2'b10);
    ready = 1'b1;
    tick();
    chk("h_drained", t_valid, 1'b0);
    retire(32'h4C, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("h_ignored", t_valid, 1'b0);
    chk("h_ret_cnt2", ret_cnt, 32'd24);

    // Fresh start, then reset in the middle of a cycle with records buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_unhalted", halted, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire(32'(32'h300 + i * 4), 5'd1, 32'd1, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("r_valid_pre", t_valid, 1'b1);
    chk("r_ret_pre", ret_cnt, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("r_valid", t_valid, 1'b0);
    chk("r_ret_cnt", ret_cnt, 32'd0);
    chk("r_drop_cnt", drop_cnt, 32'd0);
    chk("r_overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    tick();

`ifdef RETIRE_TRACE_NEXT_PC_EN
    ready = 1'b0;
    retire(32'h10, 5'd0, 32'd0, 1'b0, 1'b0);
    npc = 32'h40;
    tick();
    retire(32'h14, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("npc_disc", t_flags[2], 1'b1);
    chk("npc_val", t_npc, 32'h40);
    ready = 1'b1;
    tick();
    chk("npc_seq", t_flags[2], 1'b0);
    chk("npc_val2", t_npc, 32'h18);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits directly downstream of the hart's instruction retire interface.
- Captures one record per retired instruction (pc, inst, rd write, trap/halt flags) and buffers it in a FIFO.
- Drains records over a valid/ready stream to a trace sink (bench logger or debug port), so slow consumers do not stall the hart.
- Keeps a retired-instruction counter and a sticky overflow indicator, and freezes capture after a halt retires.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of the retired and dropped counters

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_retire_valid  in  1  hart retired an instruction this cycle
i_retire_inst  in  32  retired instruction word
i_retire_trap  in  1  instruction trapped
i_retire_halt  in  1  instruction is the halting instruction
i_retire_pc  in  32  pc of retired instruction
i_retire_next_pc  in  32  next pc (used only with the optional feature)
i_retire_rd_waddr  in  5  destination register; 0 = no write
i_retire_rd_wdata  in  32  destination write data
o_trace_valid  out  1  head record valid
i_trace_ready  in  1  sink accepts the head record
o_trace_pc  out  32  head pc
o_trace_inst  out  32  head inst
o_trace_rd_waddr  out  5  head rd
o_trace_rd_wdata  out  32  head rd data; forced to 0 when rd = 0
o_trace_flags  out  2  head flags: [0] trap, [1] halt
o_halted  out  1  a halt record has been captured
o_overflow  out  1  sticky; at least one record was dropped
o_retired_count  out  CNT_W  accepted records, saturating
o_drop_count  out  CNT_W  dropped records, saturating

Behaviour:
- Reset (asynchronous assert, synchronous release): pointers = 0, occupancy = 0, state = RUN; every output is 0.
- Push condition: i_retire_valid && state == RUN.
  - Record written at the rising edge.
  - Visible on o_trace_* with o_trace_valid = 1 one cycle later if the FIFO was empty: latency 1, no bypass.
- Pop condition: o_trace_valid && i_trace_ready.
  - Head advances at the edge.
  - Head outputs are a registered/indexed view and are stable while valid is high and ready is low.
- Occupancy: counter of width log2(DEPTH)+1.
  - Full when occupancy == DEPTH; empty when occupancy == 0.
  - Pointers wrap modulo DEPTH.
- Push while full with no pop: record is dropped, o_overflow is set (sticky until reset), o_drop_count is incremented.
- Push while full with a simultaneous pop: the push is accepted and occupancy is unchanged.
- Push and pop together while empty: only the push takes effect; the pop condition is false because valid is 0.
- o_retired_count increments on every accepted push. Both counters saturate at all-ones and never wrap.
- State machine:
  - RUN -> HALTED on a push with i_retire_halt = 1. The halt record itself is captured if space exists; if it is dropped, the state still moves to HALTED.
  - HALTED is terminal until reset: retire inputs are ignored, draining continues, and o_halted = 1.
- A trap with no halt has no state effect; only flag[0] is recorded.
- i_retire_rd_wdata is stored as 0 when i_retire_rd_waddr == 0.
- Reset mid-stream discards all buffered records immediately; o_trace_valid falls asynchronously.

Optional Feature:
- Macro: RETIRE_TRACE_NEXT_PC_EN.
- When defined:
  - Each record also stores i_retire_next_pc, presented on an extra port o_trace_next_pc (out, 32).
  - Flag bit [2] = discontinuity, set when next_pc != pc + 4; o_trace_flags widens to 3.
- When undefined: next_pc is neither stored nor output, o_trace_flags is 2 bits wide, and i_retire_next_pc is unused.

Decomposition:
- Package retire_trace_pkg holds:
  - Flag bit indices: FLAG_TRAP = 0, FLAG_HALT = 1, FLAG_DISC = 2.
  - Record field widths and the total record width (with and without next_pc).
  - State encoding: RUN, HALTED.
- Sub-module trace_fifo: generic WIDTH x DEPTH storage, pointers, occupancy, full/empty.
- The top level handles packing/unpacking, the state machine, and the counters.

Test Plan:
- Reset, then 3 retires (pc 0x0, 0x4, 0x8) with ready = 1 -> 3 records out in order, each 1 cycle after its push; o_retired_count = 3.
- ready = 0, then 20 retires with DEPTH = 16 -> 16 held, o_overflow = 1, o_drop_count = 4. After ready = 1, records drain in pc order 0x0..0x3C.
- FIFO full, push + pop in the same cycle -> occupancy stays 16, drop count unchanged, new pc appears as the 16th record.
- Retire with halt = 1 at pc 0x40, then 2 more retires -> o_halted = 1, only the halt record (flags = 2'b10) is added, o_retired_count unchanged by the later retires.
- Retire with rd = 0, wdata = 0xDEADBEEF -> o_trace_rd_wdata = 0. Retire with rd = 10, wdata = 0x2A -> rd 10, data 0x2A. Trap retire -> flags = 2'b01.
- 5 records buffered, assert i_rst mid-cycle -> o_trace_valid = 0 immediately and all counters = 0. With RETIRE_TRACE_NEXT_PC_EN defined: pc 0x10, next_pc 0x40 -> flag[2] = 1.
